// File: rtl/multi_debounce.sv
// multi_debounce: N-channel pushbutton / slide-switch debouncer.
//
// Each raw input is brought into the clk domain through a 2-flop
// synchroniser. A per-channel stability counter then advances once per
// shared prescaler tick while the synchronised input disagrees with the
// debounced level. db follows the input only after STABLE_TICKS
// consecutive disagreeing ticks.
//
// Output semantics: db is a registered level. rise, fall and rpt are
// single-cycle registered strobes with no handshake. A consumer must
// sample them on every clock, because they are never held or re-sent.
// rise and fall are mutually exclusive per channel.
//
// Optional build macro: AUTOREPEAT_EN. When it is defined, each channel
// also produces auto-repeat strobes on rpt while db is held high. When it
// is undefined, rpt is tied to zero and no repeat logic exists.
module multi_debounce #(
  parameter int N            = 4,
  parameter int TICK_CYCLES  = 1000000,
  parameter int STABLE_TICKS = 3,
  parameter int HOLD_TICKS   = 50,
  parameter int RPT_TICKS    = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw,
  output logic [N-1:0] db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] rpt,
  output logic         tick
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam int CW = (STABLE_TICKS > 2) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  // Reject nonsensical configurations at elaboration time
  if (N < 1 || TICK_CYCLES < 2 || STABLE_TICKS < 1 ||
      HOLD_TICKS < 1 || RPT_TICKS < 1) begin : g_param_check
    $error("multi_debounce: illegal parameter combination");
  end

  logic [PW-1:0] presc;
  logic [N-1:0]  sync_q1;
  logic [N-1:0]  s;
  logic [CW-1:0] cnt [N];

  // Free-running prescaler, 0..TICK_CYCLES-1; bounces never disturb it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Tick is high for the last prescaler count of each period
  assign tick = (presc == PRESC_LAST);

  // Two-flop synchroniser; nothing downstream looks at raw sw
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      s       <= '0;
    end else begin
      sync_q1 <= sw;
      s       <= sync_q1;
    end
  end

  // Per-channel stability counter, debounced level and edge strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
      db   <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        // Strobes last exactly one cycle unless a commit re-arms them
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (s[i] == db[i]) begin
          // Agreement discards any partial qualification
          cnt[i] <= '0;
        end else if (tick && (cnt[i] == CNT_LAST)) begin
          db[i]   <= s[i];
          cnt[i]  <= '0;
          rise[i] <= s[i];
          fall[i] <= ~s[i];
        end else if (tick) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RMAX = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_TICKS - 1);
  localparam logic [RW-1:0] RPT_LAST  = RW'(RPT_TICKS - 1);

  logic [RW-1:0] rcnt [N];
  logic [N-1:0]  held;

  // Auto-repeat: first strobe after HOLD_TICKS ticks high, then every
  // RPT_TICKS ticks; held marks that the initial delay has elapsed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        rcnt[i] <= '0;
      end
      held <= '0;
      rpt  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        rpt[i] <= 1'b0;
        if (!db[i] || rise[i]) begin
          rcnt[i] <= '0;
          held[i] <= 1'b0;
        end else if (tick) begin
          if (!held[i] && (rcnt[i] == HOLD_LAST)) begin
            rpt[i]  <= 1'b1;
            held[i] <= 1'b1;
            rcnt[i] <= '0;
          end else if (held[i] && (rcnt[i] == RPT_LAST)) begin
            rpt[i]  <= 1'b1;
            rcnt[i] <= '0;
          end else begin
            rcnt[i] <= rcnt[i] + RW'(1);
          end
        end
      end
    end
  end
`else
  // Repeat feature not built: the port stays, driven low
  assign rpt = '0;
`endif

endmodule

// File: tb/tb_multi_debounce.sv
// Testbench for multi_debounce with N=2, TICK_CYCLES=10, STABLE_TICKS=3,
// HOLD_TICKS=5, RPT_TICKS=2. Inputs change on the falling edge, and
// outputs are sampled on the falling edge. cyc counts rising edges since
// the last reset release. Expected strobe events are pushed as
// {cyc, rise, fall, rpt} when the stimulus is issued. A monitor pops one
// expected event whenever any strobe is seen.
module tb_multi_debounce;

  localparam int N  = 2;
  localparam int TC = 10;
  localparam int ST = 3;
  localparam int HT = 5;
  localparam int RT = 2;
  localparam int W  = 22;

  logic         clk;
  logic         reset;
  logic [N-1:0] sw;
  logic [N-1:0] db;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] rpt;
  logic         tick;

  int n_cmp;
  int n_fail;
  int cyc;
  logic [W-1:0] exp_q[$];

  multi_debounce #(
    .N(N), .TICK_CYCLES(TC), .STABLE_TICKS(ST),
    .HOLD_TICKS(HT), .RPT_TICKS(RT)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .db(db),
    .rise(rise), .fall(fall), .rpt(rpt), .tick(tick)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [W-1:0] ev(input int c, input logic [1:0] r,
                                      input logic [1:0] f, input logic [1:0] p);
    return {16'(c), r, f, p};
  endfunction

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Monitor: tick phase every cycle, and a scoreboard pop on every strobe
  always @(negedge clk) begin
    if (!reset) begin
      check("tick", 32'(tick), 32'((cyc % TC) == (TC - 1)));
      if ((rise | fall | rpt) != '0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event at cyc %0d: got rise=%b fall=%b rpt=%b, expected none",
                   cyc, rise, fall, rpt);
        end else begin
          check("event", 32'(ev(cyc, rise, fall, rpt)), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin
    reset = 1'b1;
    sw    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("reset_db",   32'(db),   32'(0));
    check("reset_rise", 32'(rise), 32'(0));
    check("reset_fall", 32'(fall), 32'(0));
    check("reset_rpt",  32'(rpt),  32'(0));
    check("reset_tick", 32'(tick), 32'(0));

    // Raise sw[0]: s[0] high after edge 7, qualifies on ticks 10,20,30
    wait_cyc(5);
    sw[0] = 1'b1;
    exp_q.push_back(ev(30, 2'b01, 2'b00, 2'b00));
`ifdef AUTOREPEAT_EN
    exp_q.push_back(ev(80,  2'b00, 2'b00, 2'b01));
    exp_q.push_back(ev(100, 2'b00, 2'b00, 2'b01));
`endif
    wait_cyc(29);
    check("s2_db_before", 32'(db), 32'(2'b00));
    wait_cyc(35);
    check("s2_db_after", 32'(db), 32'(2'b01));

    // Drop sw[0], glitch high 117..122; fall qualifies on ticks 130,140,150
    wait_cyc(105);
    sw[0] = 1'b0;
`ifdef AUTOREPEAT_EN
    exp_q.push_back(ev(120, 2'b00, 2'b00, 2'b01));
    exp_q.push_back(ev(140, 2'b00, 2'b00, 2'b01));
`endif
    exp_q.push_back(ev(150, 2'b00, 2'b01, 2'b00));
    wait_cyc(117);
    sw[0] = 1'b1;
    wait_cyc(122);
    sw[0] = 1'b0;
    wait_cyc(149);
    check("s4_db_before", 32'(db), 32'(2'b01));
    wait_cyc(155);
    check("s4_db_after", 32'(db), 32'(2'b00));

    // Toggle sw[0] every 7 cycles: never stable long enough
    for (int j = 0; j < 15; j++) begin
      wait_cyc(160 + 7 * j);
      sw[0] = ((j % 2) == 0);
    end
    wait_cyc(260);
    sw[0] = 1'b0;
    wait_cyc(270);
    check("s3_db", 32'(db), 32'(2'b00));

    // Both channels together: rise on 300, fall on 330
    wait_cyc(275);
    sw = 2'b11;
    exp_q.push_back(ev(300, 2'b11, 2'b00, 2'b00));
    wait_cyc(299);
    check("s5_db_before", 32'(db), 32'(2'b00));
    wait_cyc(305);
    check("s5_db_after", 32'(db), 32'(2'b11));
    sw = 2'b00;
    exp_q.push_back(ev(330, 2'b00, 2'b11, 2'b00));
    wait_cyc(335);
    check("s5_db_fall", 32'(db), 32'(2'b00));

    // Hold sw[0] high, then reset mid-hold
    wait_cyc(345);
    sw[0] = 1'b1;
    exp_q.push_back(ev(370, 2'b01, 2'b00, 2'b00));
`ifdef AUTOREPEAT_EN
    exp_q.push_back(ev(420, 2'b00, 2'b00, 2'b01));
    exp_q.push_back(ev(440, 2'b00, 2'b00, 2'b01));
    exp_q.push_back(ev(460, 2'b00, 2'b00, 2'b01));
`endif
    wait_cyc(375);
    check("s6_db_held", 32'(db), 32'(2'b01));
    wait_cyc(465);
    check("s6_queue_drained", 32'(exp_q.size()), 32'(0));
    reset = 1'b1;
    #1;
    check("s6_reset_db",   32'(db),   32'(0));
    check("s6_reset_rise", 32'(rise), 32'(0));
    check("s6_reset_fall", 32'(fall), 32'(0));
    check("s6_reset_rpt",  32'(rpt),  32'(0));
    check("s6_reset_tick", 32'(tick), 32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // sw[0] still high: fresh qualification on ticks 10,20,30
    exp_q.push_back(ev(30, 2'b01, 2'b00, 2'b00));
`ifdef AUTOREPEAT_EN
    exp_q.push_back(ev(80, 2'b00, 2'b00, 2'b01));
`endif
    wait_cyc(29);
    check("s6_db_requal_before", 32'(db), 32'(2'b00));
    wait_cyc(35);
    check("s6_db_requal_after", 32'(db), 32'(2'b01));
    wait_cyc(85);
    sw[0] = 1'b0;
`ifdef AUTOREPEAT_EN
    exp_q.push_back(ev(100, 2'b00, 2'b00, 2'b01));
`endif
    exp_q.push_back(ev(110, 2'b00, 2'b01, 2'b00));
    wait_cyc(115);
    check("s6_db_final", 32'(db), 32'(2'b00));
    wait_cyc(125);

    // Report any expected strobe that never appeared
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL missing_event: got none, expected %0h", exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
